// File: rtl/sd_wb_sel_ctrl_unit.sv
// Wishbone byte-select generator for the SD data DMA path: latches a transfer's
// byte window while idle and masks the partial first/last words while enabled.
module sd_wb_sel_ctrl_unit #(
    parameter int BLKSIZE_W = 12,
    parameter int BLKCNT_W  = 16
) (
    input  logic                           wb_clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [31:0]                    base_adr_i,
    input  logic [31:0]                    wbm_adr_i,
    input  logic [BLKSIZE_W+BLKCNT_W-1:0]  xfersize,
    output logic [3:0]                     wbm_sel_o
);

    localparam int XW = BLKSIZE_W + BLKCNT_W;

    logic [32:0] start_q, start_d;
    logic [32:0] end_q,   end_d;
    logic [3:0]  sel_q,   sel_d;

    // Only the word address matters; the low byte-offset bits are don't-care.
    logic unused_adr_bits;
    assign unused_adr_bits = ^wbm_adr_i[1:0];

    // Lane (3-k) is set when byte k of the word lies in [s, e); an untouched
    // word falls back to a full select.
    function automatic logic [3:0] sel_mask(input logic [29:0] word,
                                            input logic [32:0] s,
                                            input logic [32:0] e);
        logic [32:0] byte_adr;
        logic [3:0]  m;
        m = 4'h0;
        for (int k = 0; k < 4; k++) begin
            byte_adr = {1'b0, word, 2'b00} + 33'(k);
            m[3-k]   = (byte_adr >= s) && (byte_adr < e);
        end
        return (m == 4'h0) ? 4'hF : m;
    endfunction

    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        sel_d   = 4'hF;
        if (!ena) begin
            start_d = {1'b0, base_adr_i};
            end_d   = {1'b0, base_adr_i} + {{(33-XW){1'b0}}, xfersize};
        end else begin
            sel_d   = sel_mask(wbm_adr_i[31:2], start_q, end_q);
        end
    end

    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            end_q   <= '0;
            sel_q   <= 4'hF;
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
            sel_q   <= sel_d;
        end
    end

    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_sd_wb_sel_ctrl_unit.sv
// Scoreboard bench for sd_wb_sel_ctrl_unit: directed byte-window cases followed
// by randomized transfers checked against a byte-range reference model.
module tb_sd_wb_sel_ctrl_unit;

    localparam int XW = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic [31:0]   base_adr_i = '0;
    logic [31:0]   wbm_adr_i = '0;
    logic [XW-1:0] xfersize = '0;
    logic [3:0]    wbm_sel_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] want;
        int         id;
    } exp_t;
    exp_t sbq[$];
    int   step_id = 0;

    // Reference transfer window (33-bit, end exclusive).
    logic [32:0] m_start = '0;
    logic [32:0] m_end = '0;

    sd_wb_sel_ctrl_unit #(.BLKSIZE_W(12), .BLKCNT_W(16)) dut (
        .wb_clk     (clk),
        .rst        (rst),
        .ena        (ena),
        .base_adr_i (base_adr_i),
        .wbm_adr_i  (wbm_adr_i),
        .xfersize   (xfersize),
        .wbm_sel_o  (wbm_sel_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_mask(input logic [31:0] adr,
                                            input logic [32:0] s,
                                            input logic [32:0] e);
        logic [32:0] w;
        logic [3:0]  m;
        w = {1'b0, adr & 32'hFFFF_FFFC};
        m = 4'h0;
        for (int k = 0; k < 4; k++)
            if ((w + 33'(k)) >= s && (w + 33'(k)) < e) m[3-k] = 1'b1;
        if (m == 4'h0) m = 4'hF;
        return m;
    endfunction

    // One clock: drive, let the edge happen, push the expected registered output.
    // want < 0 takes the expectation from the reference model.
    task automatic step(input logic e, input logic [31:0] base, input logic [XW-1:0] size,
                        input logic [31:0] adr, input logic r, input int want);
        exp_t x;
        logic [3:0] mexp;
        ena = e; base_adr_i = base; xfersize = size; wbm_adr_i = adr; rst = r;
        @(posedge clk);
        if (r) begin
            mexp = 4'hF; m_start = '0; m_end = '0;
        end else begin
            mexp = e ? ref_mask(adr, m_start, m_end) : 4'hF;
            if (!e) begin
                m_start = {1'b0, base};
                m_end   = {1'b0, base} + {5'b0, size};
            end
        end
        x.want = (want < 0) ? mexp : want[3:0];
        x.id   = step_id;
        step_id++;
        sbq.push_back(x);
        #1;
    endtask

    logic [31:0] cur_base;
    logic [XW-1:0] cur_size;

    task automatic start_xfer(input int base, input int size);
        cur_base = base;
        cur_size = size[XW-1:0];
        for (int i = 0; i < 2; i++)
            step(1'b0, cur_base, cur_size, 32'($urandom), 1'b0, 4'hF);
    endtask

    // Hold one word address for three cycles.
    task automatic chk(input int adr, input int want);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'($urandom), XW'($urandom), adr, 1'b0, want);
    endtask

    // Monitor: the output is registered every cycle, so one entry per edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                checks++;
                if (wbm_sel_o !== x.want) begin
                    failures++;
                    $display("FAIL sel step=%0d got=%h want=%h", x.id, wbm_sel_o, x.want);
                end
            end
        end
    end

    initial begin
        logic [31:0] rb;
        logic [XW-1:0] rs;
        int n;

        #1 rst = 1'b1;
        #1;
        checks++;
        if (wbm_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL reset_async got=%h want=f", wbm_sel_o);
        end
        #5;
        step(1'b0, 32'd0, '0, 32'd0, 1'b1, 4'hF);
        step(1'b0, 32'd0, '0, 32'd0, 1'b1, 4'hF);

        // Idle with wandering address
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'($urandom), XW'($urandom), 32'($urandom), 1'b0, 4'hF);

        start_xfer(4, 1);    chk(4, 4'h8);  chk(8, 4'hF);
        start_xfer(1, 1);    chk(0, 4'h4);  chk(4, 4'hF);
        step(1'b0, 32'd0, '0, 32'd0, 1'b0, 4'hF);
        start_xfer(8, 2);    chk(8, 4'hC);
        start_xfer(11, 2);   chk(8, 4'h1);  chk(12, 4'h8); chk(16, 4'hF);
        start_xfer(20, 3);   chk(20, 4'hE);
        start_xfer(25, 3);   chk(24, 4'h7);
        start_xfer(32, 4);   chk(32, 4'hF); chk(36, 4'hF);
        start_xfer(42, 4);   chk(40, 4'h3); chk(44, 4'hC);
        start_xfer(52, 5);   chk(52, 4'hF); chk(56, 4'h8); chk(60, 4'hF);
        start_xfer(65, 5);   chk(64, 4'h7); chk(68, 4'hC);
        start_xfer(85, 8);   chk(84, 4'h7); chk(88, 4'hF); chk(92, 4'h8); chk(96, 4'hF);
        start_xfer(100, 19); chk(100, 4'hF); chk(104, 4'hF); chk(116, 4'hE); chk(120, 4'hF);
        start_xfer(101, 19); chk(100, 4'h7); chk(116, 4'hF); chk(120, 4'hF);
        start_xfer(85, 8);   chk(84, 4'h7); chk(88, 4'hF); chk(92, 4'h8); chk(96, 4'hF);
        start_xfer(85, 8);   chk(84, 4'h7); chk(88, 4'hF); chk(92, 4'h8); chk(96, 4'hF);
        start_xfer(0, 0);    chk(0, 4'hF);

        // Reset in the middle of a transfer whose output is a partial mask
        start_xfer(85, 8);
        chk(84, 4'h7);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wbm_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL reset_mid got=%h want=f", wbm_sel_o);
        end
        #5;
        step(1'b1, 32'd85, 28'd8, 32'd84, 1'b1, 4'hF);
        step(1'b1, 32'd85, 28'd8, 32'd84, 1'b0, 4'hF);
        chk(84, 4'hF);
        chk(0, 4'hF);

        // Randomized transfers against the reference model
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 3))
                0:       rb = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                1:       rb = 32'($urandom);
                default: rb = 32'($urandom_range(0, 4096));
            endcase
            rs = ($urandom_range(0, 7) == 0) ? XW'($urandom) : XW'($urandom_range(0, 40));
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++)
                step(1'b0, rb, rs, 32'($urandom), 1'b0, -1);
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                step(1'b1, 32'($urandom), XW'($urandom),
                     (rb & 32'hFFFF_FFFC) - 32'd8 + 32'($urandom_range(0, 56)),
                     ($urandom_range(0, 60) == 0), -1);
            end
        end
        step(1'b0, 32'd0, '0, 32'd0, 1'b0, -1);

        @(posedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
